// File: rtl/enc_dec_pkg.sv
// Shared types and constants for the encoder/decoder operation sequencer.
package enc_dec_pkg;

    typedef enum logic [1:0] {
        MODE_ENCODE  = 2'd0,
        MODE_DECODE  = 2'd1,
        MODE_FULL    = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_DEC  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] CTRL_ADDR_DEF = 32'h0000_0000;

    function automatic int max_lat(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/enc_dec_lat_cnt.sv
// Loadable stage-latency down-counter; tc flags the last cycle of a stage (count == 1).
module enc_dec_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(1));

endmodule

// File: rtl/enc_dec_seq.sv
// Encoder/decoder operation sequencer: CTRL write -> ENC/DEC stages -> done pulse.
// Optional completion interrupt (irq/irq_clr) when ENC_DEC_SEQ_IRQ_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a CTRL write
//   ENC   | encoder enabled for ENC_LAT cycles
//   DEC   | decoder enabled for DEC_LAT cycles
//   DONE  | one-cycle completion pulse
module enc_dec_seq
    import enc_dec_pkg::*;
#(
    parameter int                         AMBA_ADDR_WIDTH = 32,
    parameter int                         AMBA_WORD       = 32,
    parameter logic [AMBA_ADDR_WIDTH-1:0] CTRL_ADDR       = AMBA_ADDR_WIDTH'(CTRL_ADDR_DEF),
    parameter int                         ENC_LAT         = 1,
    parameter int                         DEC_LAT         = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic                       regs_wr_en,
    input  logic [AMBA_WORD-1:0]       ctrl_reg,
    output logic                       enc_ena,
    output logic                       dec_ena,
    output logic                       dec_in_sel,
    output logic                       data_out_sel,
    output logic                       operation_done,
    output logic                       busy,
    output logic                       err_mode,
    output logic                       overrun
`ifdef ENC_DEC_SEQ_IRQ_EN
    ,
    output logic                       irq,
    input  logic                       irq_clr
`endif
);

    localparam int CNT_W = $clog2(max_lat(ENC_LAT, DEC_LAT)) + 1;
    localparam logic [CNT_W-1:0] ENC_LD = CNT_W'(ENC_LAT);
    localparam logic [CNT_W-1:0] DEC_LD = CNT_W'(DEC_LAT);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_ENC  = ST_ENC;
    localparam logic [1:0] S_DEC  = ST_DEC;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state_q, state_d;
    mode_e            mode_q, mode_d;
    logic             err_mode_q, err_mode_d;
    logic             overrun_q, overrun_d;
    logic             start;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_ld_val;
    logic             cnt_tc;
    logic             unused_ctrl;

    assign start       = regs_wr_en && (paddr == CTRL_ADDR);
    assign unused_ctrl = ^ctrl_reg[AMBA_WORD-1:2];

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        err_mode_d = err_mode_q;
        overrun_d  = overrun_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_ld_val = ENC_LD;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ctrl_reg[1:0] == MODE_ILLEGAL) begin
                        err_mode_d = 1'b1;
                    end else begin
                        mode_d     = mode_e'(ctrl_reg[1:0]);
                        err_mode_d = 1'b0;
                        overrun_d  = 1'b0;
                        cnt_load   = 1'b1;
                        if (ctrl_reg[1:0] == MODE_DECODE) begin
                            state_d    = S_DEC;
                            cnt_ld_val = DEC_LD;
                        end else begin
                            state_d = S_ENC;
                        end
                    end
                end
            end
            S_ENC: begin
                if (cnt_tc) begin
                    if (mode_q == MODE_FULL) begin
                        state_d    = S_DEC;
                        cnt_load   = 1'b1;
                        cnt_ld_val = DEC_LD;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_DEC: begin
                if (cnt_tc) begin
                    state_d = S_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Any start outside IDLE (DONE included) is dropped and flagged.
        if (start && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_ENCODE;
            err_mode_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            err_mode_q <= err_mode_d;
            overrun_q  <= overrun_d;
        end
    end

    enc_dec_lat_cnt #(
        .W(CNT_W)
    ) u_lat_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_ld_val),
        .dec     (cnt_dec),
        .tc      (cnt_tc)
    );

    assign enc_ena        = (state_q == S_ENC);
    assign dec_ena        = (state_q == S_DEC);
    assign dec_in_sel     = (state_q == S_DEC) && (mode_q == MODE_FULL);
    // Mode stays latched after DONE so the output mux keeps pointing at the last result.
    assign data_out_sel   = (mode_q == MODE_DECODE) || (mode_q == MODE_FULL);
    assign operation_done = (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);
    assign err_mode       = err_mode_q;
    assign overrun        = overrun_q;

`ifdef ENC_DEC_SEQ_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (operation_done) begin
            irq_d = 1'b1;
        end else if (irq_clr) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: doc/enc_dec_seq.md
# enc_dec_seq

Parametrised operation sequencer for the encoder/decoder datapath; next generation of the encoder/decoder control logic. Decodes a CTRL-register write from the APB register file into a start, latches the requested mode, drives encoder/decoder enables and datapath mux selects for parametrised per-stage latencies, and reports completion. Adds busy tracking, overrun and illegal-mode detection over the previous fixed 1/2-cycle control. Sits between the APB register block and the encoder/decoder datapath.

## Interface
- AMBA_ADDR_WIDTH, 32, APB address width
- AMBA_WORD, 32, register word width
- CTRL_ADDR, 0, address whose write starts an operation
- ENC_LAT, 1, encoder stage cycles (≥1)
- DEC_LAT, 1, decoder stage cycles (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- paddr  in  AMBA_ADDR_WIDTH  APB address of current register write
- regs_wr_en  in  1  register write strobe
- ctrl_reg  in  AMBA_WORD  CTRL register value; bits [1:0] = mode
- enc_ena  out  1  encoder enable
- dec_ena  out  1  decoder enable
- dec_in_sel  out  1  decoder input: 0 data_in, 1 encoder output
- data_out_sel  out  1  data_out: 0 encoder output, 1 decoder output
- operation_done  out  1  single-cycle completion pulse
- busy  out  1  operation in progress
- err_mode  out  1  sticky: illegal mode requested
- overrun  out  1  sticky: start dropped while busy
- irq  out  1  (only with ENC_DEC_SEQ_IRQ_EN) completion interrupt
- irq_clr  in  1  (only with ENC_DEC_SEQ_IRQ_EN) interrupt clear

## Operation
- Start = regs_wr_en & (paddr == CTRL_ADDR), sampled at rising clk.
- Mode from ctrl_reg[1:0] at start: 00 ENCODE, 01 DECODE, 10 FULL (encode then decode), 11 illegal.
- FSM states: IDLE, ENC, DEC, DONE.
- IDLE + start, mode ENCODE or FULL -> ENC; mode DECODE -> DEC; mode 11 -> stay IDLE, set err_mode. Valid start clears err_mode and overrun.
- ENC: enc_ena=1 for ENC_LAT cycles; then FULL -> DEC, ENCODE -> DONE.
- DEC: dec_ena=1 for DEC_LAT cycles; then -> DONE.
- DONE: operation_done=1 one cycle; -> IDLE.
- busy=1 in ENC, DEC, DONE. Start while busy: ignored, set overrun; running operation unaffected.
- dec_in_sel=1 only in DEC with latched mode FULL.
- data_out_sel = latched mode is DECODE or FULL; held after DONE until next valid start (output mux remains valid for readback).
- Stage counter: down-counter, width $clog2(max(ENC_LAT,DEC_LAT))+1, loaded on state entry, terminal at 1.
- ctrl_reg changes mid-operation have no effect (mode latched).

## Timing
- All outputs reset to 0; async reset mid-operation returns to IDLE immediately, no operation_done.
- Start sampled at edge T: first enable cycle T+1.
- ENCODE: operation_done in cycle T+1+ENC_LAT. DECODE: T+1+DEC_LAT. FULL: T+1+ENC_LAT+DEC_LAT.
- Start coincident with DONE cycle: dropped, overrun set. Start in cycle after DONE accepted.
- err_mode/overrun set on the edge following the offending write.

## Configuration
- ENC_DEC_SEQ_IRQ_EN defined: irq and irq_clr ports exist; irq sets on the edge where operation_done is high, held until irq_clr sampled high; irq_clr and done in same cycle -> irq stays set (set wins). Reset value 0.
- Not defined: ports absent, no irq logic.

## Structure
- Package enc_dec_pkg: mode enum (ENCODE, DECODE, FULL, ILLEGAL), FSM state enum, default CTRL_ADDR constant.
- Sub-module enc_dec_lat_cnt: loadable down-counter with terminal-count flag, width parameter; instantiated once, shared across ENC/DEC.

## Test plan
- ENC_LAT=2, DEC_LAT=3; write mode 00 at T -> enc_ena T+1..T+2, operation_done at T+3, data_out_sel=0, busy T+1..T+3.
- Same params, mode 10 -> enc_ena 2 cycles, dec_ena+dec_in_sel 3 cycles, operation_done at T+6, data_out_sel=1 held after.
- Mode 11 -> err_mode=1 from T+1, busy=0, no done; next mode 01 write clears err_mode, done at T'+4.
- Mode 10 started, second CTRL write at T+3 -> overrun=1, done still at T+6, no second operation.
- Reset asserted at T+2 of mode 10 -> all outputs 0 immediately; write after reset release runs normally.
- With ENC_DEC_SEQ_IRQ_EN: done -> irq=1 held; irq_clr pulse -> irq=0 next edge; irq_clr coincident with done -> irq stays 1.
